// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM states, segment constants and frame sizing for the serial display driver
package disp_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;
  localparam int SEG_BITS = 8;
  localparam logic [SEG_BITS-1:0] SEG_BLANK = 8'h00;
  function automatic int frame_bits(input int n);
    return n * SEG_BITS;
  endfunction
endpackage

// File: rtl/bcd2segments.sv
// bcd2segments: BCD nibble to active-high {dp,g,f,e,d,c,b,a} segment code; 10..15 show A..F
module bcd2segments (
  input  logic [3:0] bcd,
  output logic [7:0] segments
);
  always_comb
    case (bcd)
      4'h0: segments = 8'h3F;
      4'h1: segments = 8'h06;
      4'h2: segments = 8'h5B;
      4'h3: segments = 8'h4F;
      4'h4: segments = 8'h66;
      4'h5: segments = 8'h6D;
      4'h6: segments = 8'h7D;
      4'h7: segments = 8'h07;
      4'h8: segments = 8'h7F;
      4'h9: segments = 8'h6F;
      4'hA: segments = 8'h77;
      4'hB: segments = 8'h7C;
      4'hC: segments = 8'h39;
      4'hD: segments = 8'h5E;
      4'hE: segments = 8'h79;
      default: segments = 8'h71;
    endcase
endmodule

// File: rtl/lz_blanker.sv
// lz_blanker: flags each zero digit above the most significant nonzero one; digit 0 never flagged
module lz_blanker #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   blank
);
  always_comb begin
    logic run;
    run = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run = run && bcd[4*i +: 4] == 4'd0;
      blank[i] = run;
    end
  end
endmodule

// File: rtl/display_serializer_n.sv
// display_serializer_n: decodes NUM_DIGITS BCD digits and shifts the frame out one bit per
// enable tick, followed by a latch strobe and an idle gap; data_ready forces an early frame.
module display_serializer_n
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SEG_BITS      = 8,
  parameter int SEND_INTERVAL = 3000,
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit LZ_BLANK      = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    data_ready,
  output logic                    data_sent,
  output logic                    data_out,
  output logic                    sending_data,
  output logic                    latch_out,
  output logic                    busy
);
  localparam int FRAME_BITS = frame_bits(NUM_DIGITS);
  localparam int BW = $clog2(FRAME_BITS) + 1;
  localparam int GW = $clog2(SEND_INTERVAL) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);
  localparam logic [GW-1:0] GAP_LAST = GW'(SEND_INTERVAL - 1);
  logic [FRAME_BITS-1:0] raw, frame, ordered, shreg_q, shreg_d;
  logic [NUM_DIGITS-1:0] blank;
  state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic pending_q, pending_d, data_out_q, data_out_d, sending_q, sending_d;
  logic latch_q, latch_d, sent_q, sent_d;
  lz_blanker #(.NUM_DIGITS(NUM_DIGITS)) u_blank (.bcd(bcd_in), .blank(blank));
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd2segments u_dec (.bcd(bcd_in[4*g +: 4]), .segments(raw[SEG_BITS*g +: SEG_BITS]));
    assign frame[SEG_BITS*g +: SEG_BITS] = LZ_BLANK && blank[g] ? SEG_BLANK : raw[SEG_BITS*g +: SEG_BITS];
  end
  // Reordering up front lets the shifter always emit bit 0 first
  always_comb
    for (int i = 0; i < FRAME_BITS; i++) ordered[i] = MSB_FIRST ? frame[FRAME_BITS-1-i] : frame[i];
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shreg_d = shreg_q;
    data_out_d = data_out_q;
    sending_d = sending_q;
    latch_d = latch_q;
    sent_d = 1'b0;
    if (enable)
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          shreg_d = ordered >> 1;
          data_out_d = ordered[0];
          sending_d = 1'b1;
          bit_cnt_d = BW'(1);
          state_d = SHIFT;
        end
        SHIFT:
          if (bit_cnt_q == BIT_LAST) begin
            data_out_d = 1'b0;
            sending_d = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            data_out_d = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        LATCH: begin
          latch_d = 1'b0;
          gap_cnt_d = '0;
          sent_d = 1'b1;
          state_d = GAP;
        end
        GAP:
          if (pending_q || gap_cnt_q == GAP_LAST) state_d = LOAD;
          else gap_cnt_d = gap_cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    // A request coinciding with LOAD entry is served by that very frame
    pending_d = state_d == LOAD && state_q != LOAD ? 1'b0 :
                data_ready && state_q != IDLE ? 1'b1 : pending_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shreg_q <= '0;
      pending_q <= 1'b0;
      data_out_q <= 1'b0;
      sending_q <= 1'b0;
      latch_q <= 1'b0;
      sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shreg_q <= shreg_d;
      pending_q <= pending_d;
      data_out_q <= data_out_d;
      sending_q <= sending_d;
      latch_q <= latch_d;
      sent_q <= sent_d;
    end
  assign data_out = data_out_q;
  assign sending_data = sending_q;
  assign latch_out = latch_q;
  assign data_sent = sent_q;
  assign busy = state_q == LOAD || state_q == SHIFT || state_q == LATCH;
endmodule
